// File: rtl/seq_mult_16_if.sv
// Start/done handshake and operand/result bus
// for the 16x16 sequential multiplier.
interface seq_mult_16_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mult_16.sv
// Unsigned 16x16 shift-add multiplier, one
// partial product per cycle through a Cla_16.
module Cla_16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        c0,
  output logic [15:0] s,
  output logic        c16,
  output logic        G,
  output logic        P
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, pg;
  logic [4:0]  cg;

  assign g = x & y;
  assign p = x ^ y;

  always_comb begin
    gg = '0;
    pg = '0;
    cg = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1]
               & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
    // Second-level lookahead across groups
    cg[0] = c0;
    cg[1] = gg[0] | (pg[0] & c0);
    cg[2] = gg[1] | (pg[1] & gg[0])
          | (pg[1] & pg[0] & c0);
    cg[3] = gg[2] | (pg[2] & gg[1])
          | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & c0);
    cg[4] = gg[3] | (pg[3] & gg[2])
          | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0]
             & c0);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = g[4*k]
               | (p[4*k] & cg[k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & cg[k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k]
                  & cg[k]);
    end
  end

  assign s   = p ^ c;
  assign c16 = cg[4];
  assign G   = gg[3] | (pg[3] & gg[2])
             | (pg[3] & pg[2] & gg[1])
             | (pg[3] & pg[2] & pg[1] & gg[0]);
  assign P   = &pg;
endmodule

module seq_mult_16 #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  seq_mult_16_if.slave   m
);
  if (WIDTH != 16) begin : g_width_chk
    $error("seq_mult_16 supports WIDTH=16 only");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [4:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0] cla_y, cla_s;
  logic             cla_c16;
  logic             cla_g_unused;
  logic             cla_p_unused;

  assign cla_y = lo_q[0] ? mcand_q : '0;

  Cla_16 u_cla (
    .x   (hi_q),
    .y   (cla_y),
    .c0  (1'b0),
    .s   (cla_s),
    .c16 (cla_c16),
    .G   (cla_g_unused),
    .P   (cla_p_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (m.start) state_d = RUN;
      RUN:  if (cnt_q == 5'd15) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m.busy = (state_q == RUN);
    m.done = (state_q == DONE);
  end

  always_comb begin
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (m.start) begin
          mcand_d = m.a;
          hi_d    = '0;
          lo_d    = m.b;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // 33-bit {carry,sum,lo} shifted right
        {hi_d, lo_d} = {cla_c16, cla_s,
                        lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 5'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m.product = {hi_q, lo_q};
endmodule
